// File: rtl/square_plotter.sv
// -----------------------------------------------------------------------------
// square_plotter
//
// Pixel-expansion stage between the direction/colour state machine and the VGA
// adapter. Accepts one square request (top-left x/y plus colour) at a time and
// expands it into SIZE*SIZE pixel writes, one per clock, in row-major order.
// A one-entry holding register lets upstream queue the next square while the
// current one is being drawn.
//
// Parameters:
//   SIZE   side length of the square in pixels (legal range 1..16)
//   X_MAX  largest visible x coordinate; pixels beyond it are not plotted
//   Y_MAX  largest visible y coordinate; pixels beyond it are not plotted
//
// Ports:
//   clock       system clock, rising edge
//   reset_n     synchronous active-low reset
//   req_valid   upstream presents a request on req_x/req_y/req_color
//   req_ready   holding register empty; request taken when valid && ready
//   req_x       top-left x of the square
//   req_y       top-left y of the square
//   req_color   colour of the square
//   vga_x       pixel x to the adapter (0 outside drawing)
//   vga_y       pixel y to the adapter (0 outside drawing)
//   vga_colour  pixel colour to the adapter (0 outside drawing)
//   vga_plot    write strobe for the pixel on vga_x/vga_y
//   busy        drawing, finishing, or a request is waiting in the hold
//   done        one-cycle pulse after the last pixel of a square
// -----------------------------------------------------------------------------
module square_plotter #(
  parameter int SIZE  = 4,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_x,
  input  logic [6:0] req_y,
  input  logic [2:0] req_color,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter value of the last column / last row of a square.
  localparam logic [3:0] LAST  = 4'(SIZE - 1);
  // Visible limits at the width of the un-wrapped coordinate sums.
  localparam logic [8:0] X_LIM = 9'(X_MAX);
  localparam logic [7:0] Y_LIM = 8'(Y_MAX);

  // Holding register (one queued request).
  logic [7:0] hold_x_r;
  logic [6:0] hold_y_r;
  logic [2:0] hold_color_r;
  logic       hold_valid_r;

  // Working registers for the square being drawn.
  state_t     state_r;
  logic [7:0] base_x_r;
  logic [6:0] base_y_r;
  logic [2:0] color_r;
  logic [3:0] cx_r;
  logic [3:0] cy_r;
  logic       done_r;

  // Pixel datapath.
  logic [8:0] x_sum_s;
  logic [7:0] y_sum_s;
  logic       clip_s;
  logic       accept_s;
  logic       load_s;

  assign accept_s  = req_valid && !hold_valid_r;
  // The hold is drained only from IDLE; req_ready is low whenever it is full,
  // so a capture and a drain can never coincide on the same edge.
  assign load_s    = (state_r == IDLE) && hold_valid_r;

  assign req_ready = ~hold_valid_r;
  assign busy      = (state_r != IDLE) || hold_valid_r;
  assign done      = done_r;

  // Holding register: capture on acceptance, release when IDLE loads it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hold_x_r     <= 8'd0;
      hold_y_r     <= 7'd0;
      hold_color_r <= 3'd0;
      hold_valid_r <= 1'b0;
    end else if (accept_s) begin
      hold_x_r     <= req_x;
      hold_y_r     <= req_y;
      hold_color_r <= req_color;
      hold_valid_r <= 1'b1;
    end else if (load_s) begin
      hold_valid_r <= 1'b0;
    end else begin
      hold_valid_r <= hold_valid_r;
    end
  end

  // Drawing FSM: loads the hold, walks cx/cy row-major, pulses done.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      base_x_r <= 8'd0;
      base_y_r <= 7'd0;
      color_r  <= 3'd0;
      cx_r     <= 4'd0;
      cy_r     <= 4'd0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (hold_valid_r) begin
            base_x_r <= hold_x_r;
            base_y_r <= hold_y_r;
            color_r  <= hold_color_r;
            cx_r     <= 4'd0;
            cy_r     <= 4'd0;
            state_r  <= DRAW;
          end else begin
            state_r  <= IDLE;
          end
        end
        DRAW: begin
          // Counters advance through clipped pixels too, so every square
          // takes exactly SIZE*SIZE cycles regardless of position.
          if (cx_r == LAST) begin
            cx_r <= 4'd0;
            cy_r <= cy_r + 4'd1;
            if (cy_r == LAST) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= DRAW;
              done_r  <= 1'b0;
            end
          end else begin
            cx_r    <= cx_r + 4'd1;
            state_r <= DRAW;
            done_r  <= 1'b0;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Coordinate sums are one bit wider than the screen coordinates so a
  // square hanging off the right/bottom edge is clipped rather than wrapped.
  always_comb begin
    x_sum_s = {1'b0, base_x_r} + {5'd0, cx_r};
    y_sum_s = {1'b0, base_y_r} + {4'd0, cy_r};
    clip_s  = (x_sum_s > X_LIM) || (y_sum_s > Y_LIM);
  end

  // Pixel outputs: live only in DRAW, forced to zero otherwise.
  always_comb begin
    vga_x      = 8'd0;
    vga_y      = 7'd0;
    vga_colour = 3'd0;
    vga_plot   = 1'b0;
    if (state_r == DRAW) begin
      vga_x      = x_sum_s[7:0];
      vga_y      = y_sum_s[6:0];
      vga_colour = color_r;
      vga_plot   = !clip_s;
    end else begin
      vga_x      = 8'd0;
      vga_y      = 7'd0;
      vga_colour = 3'd0;
      vga_plot   = 1'b0;
    end
  end

endmodule

// File: tb/tb_square_plotter.sv
// -----------------------------------------------------------------------------
// tb_square_plotter
//
// Scoreboard bench for square_plotter. When a request is accepted the bench
// pushes the per-cycle outputs it expects ({done, plot, x, y, colour}) onto a
// queue; a negedge monitor pops one entry per cycle and compares it with the
// DUT. Handshake and busy behaviour are checked directly in the scenarios.
// -----------------------------------------------------------------------------
module tb_square_plotter;

  localparam int S = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_x;
  logic [6:0] req_y;
  logic [2:0] req_color;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected per-cycle outputs: {done, plot, x[7:0], y[6:0], colour[2:0]}.
  logic [19:0] exp_q[$];

  square_plotter #(.SIZE(S), .X_MAX(159), .Y_MAX(119)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_color  (req_color),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .done       (done)
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(20'd0);
  endtask

  // Expected pixel stream for one square followed by its done cycle.
  task automatic expect_square(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    logic [8:0] xs;
    logic [7:0] ys;
    logic       pl;
    for (int r = 0; r < S; r++) begin
      for (int k = 0; k < S; k++) begin
        xs = {1'b0, x} + 9'(k);
        ys = {1'b0, y} + 8'(r);
        pl = (xs <= 9'd159) && (ys <= 8'd119);
        exp_q.push_back({1'b0, pl, xs[7:0], ys[6:0], c});
      end
    end
    exp_q.push_back({1'b1, 1'b0, 8'd0, 7'd0, 3'd0});
  endtask

  // Scoreboard monitor: compare one expected cycle per negedge.
  always @(negedge clock) begin
    logic [19:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("pixel", {12'd0, done, vga_plot, vga_x, vga_y, vga_colour}, {12'd0, e});
    end
  end

  // One isolated square: accept at edge 0, run to the first idle cycle.
  task automatic run_single(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    req_x = x; req_y = y; req_color = c; req_valid = 1'b1;
    check_eq("rdy_pre", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    push_idle(1);
    expect_square(x, y, c);
    push_idle(1);
    for (int cyc = 0; cyc <= S*S + 2; cyc++) begin
      check_eq("busy_single", {31'd0, busy}, {31'd0, (cyc <= S*S + 1)});
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    // Reset held for two edges with a request presented: nothing captured.
    reset_n = 1'b0; req_valid = 1'b1; req_x = 8'd5; req_y = 7'd6; req_color = 3'd3;
    tick();
    tick();
    check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_busy",  {31'd0, busy},      32'd0);
    check_eq("rst_done",  {31'd0, done},      32'd0);
    check_eq("rst_plot",  {31'd0, vga_plot},  32'd0);
    check_eq("rst_xyc",   {12'd0, vga_x, vga_y, vga_colour, 2'd0}, 32'd0);
    req_valid = 1'b0;
    reset_n = 1'b1;
    tick();
    check_eq("post_rst_ready", {31'd0, req_ready}, 32'd1);
    check_eq("post_rst_busy",  {31'd0, busy},      32'd0);

    // Single square in the middle of the screen.
    run_single(8'd78, 7'd54, 3'd7);

    // Queued request plus a third request waiting behind it.
    req_x = 8'd78; req_y = 7'd54; req_color = 3'd7; req_valid = 1'b1;
    tick();
    req_x = 8'd82; req_y = 7'd58; req_color = 3'd2;
    push_idle(1);
    expect_square(8'd78, 7'd54, 3'd7);
    push_idle(1);
    for (int cyc = 0; cyc <= 55; cyc++) begin
      if (cyc == 0) check_eq("q_rdy_c0", {31'd0, req_ready}, 32'd0);
      if (cyc == 1) check_eq("q_rdy_c1", {31'd0, req_ready}, 32'd1);
      if (cyc == 2) begin
        expect_square(8'd82, 7'd58, 3'd2);
        push_idle(1);
        req_x = 8'd10; req_y = 7'd100; req_color = 3'd5;
      end
      if (cyc >= 2 && cyc <= 18) check_eq("q_rdy_full", {31'd0, req_ready}, 32'd0);
      if (cyc == 19) check_eq("q_rdy_free", {31'd0, req_ready}, 32'd1);
      if (cyc == 20) begin
        expect_square(8'd10, 7'd100, 3'd5);
        push_idle(1);
        req_valid = 1'b0;
      end
      if (cyc == 53) check_eq("q_busy_53", {31'd0, busy}, 32'd1);
      if (cyc == 54) check_eq("q_busy_54", {31'd0, busy}, 32'd0);
      tick();
    end

    // Clipping at the bottom-right corner, then a square past both edges.
    run_single(8'd158, 7'd118, 3'd4);
    run_single(8'd254, 7'd126, 3'd1);

    // Reset on the 6th pixel with a request held: abandoned, nothing drawn.
    req_x = 8'd30; req_y = 7'd40; req_color = 3'd6; req_valid = 1'b1;
    tick();
    req_x = 8'd50; req_y = 7'd60; req_color = 3'd1;
    push_idle(1);
    expect_square(8'd30, 7'd40, 3'd6);
    push_idle(1);
    for (int cyc = 0; cyc <= 5; cyc++) begin
      if (cyc == 2) begin
        check_eq("mr_held", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b0;
      end
      tick();
    end
    reset_n = 1'b0;
    tick();
    exp_q.delete();
    push_idle(30);
    check_eq("mr_plot",  {31'd0, vga_plot},  32'd0);
    check_eq("mr_busy",  {31'd0, busy},      32'd0);
    check_eq("mr_ready", {31'd0, req_ready}, 32'd1);
    reset_n = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      check_eq("mr_idle_busy", {31'd0, busy}, 32'd0);
      tick();
    end

    // Backpressure: request inputs churn while the hold is full.
    req_x = 8'd20; req_y = 7'd30; req_color = 3'd3; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    push_idle(1);
    expect_square(8'd20, 7'd30, 3'd3);
    push_idle(1);
    for (int cyc = 0; cyc <= 36; cyc++) begin
      if (cyc == 1) begin
        req_x = 8'd40; req_y = 7'd50; req_color = 3'd5; req_valid = 1'b1;
        check_eq("bp_rdy_c1", {31'd0, req_ready}, 32'd1);
      end
      if (cyc == 2) begin
        expect_square(8'd40, 7'd50, 3'd5);
        push_idle(1);
      end
      if (cyc >= 2 && cyc <= 18) begin
        req_x = 8'($urandom); req_y = 7'($urandom); req_color = 3'($urandom);
        check_eq("bp_rdy_full", {31'd0, req_ready}, 32'd0);
      end
      if (cyc == 18) req_valid = 1'b0;
      if (cyc == 36) check_eq("bp_busy_end", {31'd0, busy}, 32'd0);
      tick();
    end

    check_eq("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/square_plotter.md
# square_plotter

Pixel-expansion stage between the direction/colour state machine and the VGA adapter. It accepts one square request at a time: a top-left coordinate plus a colour. It expands the request into SIZE×SIZE individual pixel writes, one per clock, with a plot strobe. A one-entry holding register lets upstream queue the next square while the current one is drawn.

## Interface
- SIZE, 4, side length of the square in pixels; legal range 1..16
- X_MAX, 159, largest visible x coordinate; pixels beyond it are clipped
- Y_MAX, 119, largest visible y coordinate; pixels beyond it are clipped
- clock  in  1  system clock; all state changes on the rising edge
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  upstream has a square request on req_x/req_y/req_color
- req_ready  out  1  holding register empty; the request is accepted on an edge where req_valid && req_ready
- req_x  in  8  top-left x of the square
- req_y  in  7  top-left y of the square
- req_color  in  3  colour of the square
- vga_x  out  8  pixel x to the adapter
- vga_y  out  7  pixel y to the adapter
- vga_colour  out  3  pixel colour to the adapter
- vga_plot  out  1  write strobe; the pixel on vga_x/vga_y is written this cycle
- busy  out  1  state != IDLE or holding register full
- done  out  1  one-cycle pulse after the last pixel of a square

## Operation
- Holding register: hold_x, hold_y, hold_color and hold_valid. req_ready = ~hold_valid. It captures the request on acceptance and sets hold_valid.
- Working registers: base_x, base_y, color, and 4-bit counters cx and cy.
- FSM states: IDLE, DRAW, DONE.
  - IDLE: if hold_valid, copy hold into the working registers, clear cx/cy, clear hold_valid, and go to DRAW. Otherwise stay in IDLE.
  - DRAW: every cycle presents pixel (base_x+cx, base_y+cy).
    - If cx == SIZE-1: cx goes to 0 and cy increments. Otherwise cx increments.
    - When cx == SIZE-1 and cy == SIZE-1, go to DONE.
    - Order is row-major: x varies fastest.
  - DONE: done=1 for this cycle only, then go to IDLE.
- The holding register accepts a new request in any state, including during DRAW and DONE, whenever it is empty.
- Arithmetic: x sum is computed 9 bits wide and y sum 8 bits wide, so there is no wrap-around. Clip rule: if x sum > X_MAX or y sum > Y_MAX, vga_plot=0 for that pixel.
  - The counters still advance through clipped pixels, so a square always takes exactly SIZE² DRAW cycles.
  - vga_x and vga_y carry the low 8 and 7 bits of the sums.
- Pixel outputs are combinational from the working registers:
  - vga_plot = (state == DRAW) && !clip.
  - vga_x, vga_y and vga_colour are 0 outside DRAW.
- While hold_valid=1, req_x/req_y/req_color changes are ignored. Upstream must hold req_valid until it is accepted.
- Reset (reset_n=0 at an edge): state=IDLE, hold_valid=0, all working registers and counters cleared. An in-progress square is abandoned with no done pulse, and a pending held request is dropped.

## Timing
- Output values after reset: req_ready=1, busy=0, done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0.
- Cycle numbering: the request is accepted at edge 0.
  - Cycle 0: IDLE with hold_valid=1, so req_ready=0.
  - Cycles 1..SIZE²: DRAW. First pixel appears 1 cycle after acceptance; req_ready=1 again from cycle 1.
  - Cycle SIZE²+1: DONE, done=1.
  - Cycle SIZE²+2: IDLE.
- A request held during drawing loads at the end of cycle SIZE²+2, so its first pixel appears at cycle SIZE²+3.
- Back-to-back throughput is SIZE²+2 cycles per square, with 2 non-plot cycles (DONE and IDLE) between squares.
- busy rises the cycle after acceptance and falls in the first IDLE cycle with hold empty.

## Test plan
- Reset: hold reset_n=0 for 2 cycles with req_valid=1 → req_ready=1, busy=0, done=0, vga_plot=0, vga_x/vga_y/vga_colour=0, and no capture.
- Single square (SIZE=4): request (78,54,7) accepted at edge 0 → vga_plot=1 on cycles 1..16.
  - Pixels in order (78,54),(79,54),(80,54),(81,54),(78,55)…(81,57), all with colour 7.
  - done=1 only on cycle 17; busy=0 from cycle 18.
- Queued request: (78,54,7) at edge 0, then (82,58,2) with req_valid held.
  - Second request accepted at edge 2.
  - A third request sees req_ready=0 through cycle 18.
  - Second square plots on cycles 19..34 starting at (82,58) with colour 2.
- Clipping: request (158,118,4) → plot=1 only for (158,118), (159,118), (158,119) and (159,119).
  - The other 12 DRAW cycles have plot=0.
  - done still occurs 17 cycles after acceptance.
- Reset mid-draw: assert reset_n=0 on the 6th pixel with a request held → next cycle vga_plot=0, busy=0, req_ready=1; no done pulse; the held request never draws.
- Backpressure: with hold full, toggle req_x each cycle → req_ready stays 0 and the drawn square uses only the originally accepted coordinates.
